// File: rtl/quad_sevenseg_scanner.sv
// quad_sevenseg_scanner: divides the clock into a scan tick and multiplexes four hex digits onto active-low seven-segment pins
module quad_sevenseg_scanner #(
  parameter int MAX_COUNT = 100000,
  parameter int CTR_WIDTH = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  output logic [6:0] cathodes,
  output logic [7:0] anodes,
  output logic       tick
);
  localparam logic [CTR_WIDTH-1:0] LAST = CTR_WIDTH'(MAX_COUNT - 1);
  logic [CTR_WIDTH-1:0] count;
  logic [1:0] sel;
  logic [3:0] cur;
  logic [6:0] seg;
  assign tick = count == LAST;
  always_comb begin
    cur = sel == 2'd0 ? digit0 : sel == 2'd1 ? digit1 : sel == 2'd2 ? digit2 : digit3;
    case (cur)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      sel      <= 2'd0;
      anodes   <= 8'hFF;
      cathodes <= 7'h7F;
    end else begin
      count    <= tick ? '0 : count + 1'b1;
      sel      <= sel + {1'b0, tick};
      anodes   <= {4'hF, ~(4'b0001 << sel)};
      cathodes <= seg;
    end
  end
endmodule

// File: tb/tb_quad_sevenseg_scanner.sv
// tb_quad_sevenseg_scanner: scoreboard bench driving directed digit vectors and checking display pins every cycle
`timescale 1us/1ns
module tb_quad_sevenseg_scanner;
  typedef struct packed {
    logic [7:0] an;
    logic [6:0] ca;
    logic       tk;
    logic [7:0] id;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] digit0 = '0, digit1 = '0, digit2 = '0, digit3 = '0;
  logic [6:0] cathodes;
  logic [7:0] anodes;
  logic tick;
  logic [7:0] phase = '0;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int k = 0;
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  always #500 clk = ~clk;
  quad_sevenseg_scanner #(.MAX_COUNT(4), .CTR_WIDTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .digit0(digit0),
    .digit1(digit1),
    .digit2(digit2),
    .digit3(digit3),
    .cathodes(cathodes),
    .anodes(anodes),
    .tick(tick)
  );
  task automatic step(input logic r, input logic [15:0] d);
    exp_t e;
    int slot;
    logic [3:0] dv;
    @(negedge clk);
    reset = r;
    {digit3, digit2, digit1, digit0} = d;
    if (r) begin
      k = 0;
      e.an = 8'hFF;
      e.ca = 7'h7F;
      e.tk = 1'b0;
    end else begin
      k++;
      slot = ((k - 1) / 4) % 4;
      dv = d[slot*4 +: 4];
      e.an = 8'hFF ^ (8'd1 << slot);
      e.ca = seg_tab[dv];
      e.tk = (k % 4) == 3;
    end
    e.id = phase;
    q.push_back(e);
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({anodes, cathodes, tick} !== {e.an, e.ca, e.tk}) begin
        errors++;
        $display("FAIL phase%0d k=%0d: got anodes=%h cathodes=%h tick=%b, expected anodes=%h cathodes=%h tick=%b",
                 e.id, k, anodes, cathodes, tick, e.an, e.ca, e.tk);
      end
    end
  end
  initial begin
    phase = 8'd1;
    step(1'b1, 16'h1234);
    phase = 8'd2;
    repeat (40) step(1'b0, 16'h1234);
    phase = 8'd4;
    repeat (9) step(1'b0, 16'h1234);
    repeat (50) step(1'b0, 16'h8765);
    repeat (20) step(1'b0, 16'h6789);
    phase = 8'd5;
    for (int v = 0; v < 16; v++) repeat (16) step(1'b0, {12'h123, 4'(v)});
    phase = 8'd6;
    step(1'b1, 16'h1234);
    while (k < 10) step(1'b0, 16'h1234);
    step(1'b1, 16'h1234);
    repeat (12) step(1'b0, 16'h1234);
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
